// File: rtl/ysyx_23060072_mem_arbiter.sv
// Two-master (fetch / load-store) arbiter onto one shared memory port.
// At most one transaction is in flight. A cycle counter forces an error completion if memory stalls.
module ysyx_23060072_mem_arbiter #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,

    input  logic        ls_req_valid,
    input  logic [31:0] ls_req_addr,
    input  logic        ls_req_wen,
    input  logic [31:0] ls_req_wdata,
    input  logic [3:0]  ls_req_wmask,
    output logic        ls_req_ready,
    output logic        ls_rsp_valid,
    output logic [31:0] ls_rsp_data,
    output logic        ls_rsp_err,

    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic        OWN_IF   = 1'b0;
    localparam logic        OWN_LS   = 1'b1;
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYC);

    state_t      state_q, state_d;
    logic        last_owner_q, last_owner_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;

    logic        if_rsp_valid_q, if_rsp_valid_d;
    logic        if_rsp_err_q, if_rsp_err_d;
    logic [31:0] if_rsp_data_q, if_rsp_data_d;
    logic        ls_rsp_valid_q, ls_rsp_valid_d;
    logic        ls_rsp_err_q, ls_rsp_err_d;
    logic [31:0] ls_rsp_data_q, ls_rsp_data_d;

    logic        grant_if, grant_ls;
    logic [15:0] cnt_inc;
    logic        timeout_hit;
    logic        rsp_fire;
    logic        rsp_err;
    logic [31:0] rsp_data;

    assign cnt_inc     = cnt_q + 16'd1;
    assign timeout_hit = (cnt_inc == TO_LIMIT);

    // Grants are gated by rst_n so the ready outputs also read 0 while reset is held.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state_q == IDLE && rst_n) begin
            if (if_req_valid && ls_req_valid) begin
                if (last_owner_q == OWN_IF) grant_ls = 1'b1;
                else                        grant_if = 1'b1;
            end else if (if_req_valid) begin
                grant_if = 1'b1;
            end else if (ls_req_valid) begin
                grant_ls = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        last_owner_d   = last_owner_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        wen_d          = wen_q;
        wdata_d        = wdata_q;
        wmask_d        = wmask_q;
        if_rsp_valid_d = 1'b0;
        if_rsp_err_d   = 1'b0;
        if_rsp_data_d  = if_rsp_data_q;
        ls_rsp_valid_d = 1'b0;
        ls_rsp_err_d   = 1'b0;
        ls_rsp_data_d  = ls_rsp_data_q;
        rsp_fire       = 1'b0;
        rsp_err        = 1'b0;
        rsp_data       = 32'h0;

        unique case (state_q)
            IDLE: begin
                if (grant_if || grant_ls) begin
                    state_d      = ISSUE;
                    last_owner_d = grant_ls ? OWN_LS : OWN_IF;
                    cnt_d        = 16'd0;
                    addr_d       = grant_ls ? ls_req_addr  : if_req_addr;
                    wen_d        = grant_ls & ls_req_wen;
                    wdata_d      = grant_ls ? ls_req_wdata : 32'h0;
                    wmask_d      = grant_ls ? ls_req_wmask : 4'h0;
                end
            end
            ISSUE: begin
                cnt_d = cnt_inc;
                // A response seen here, even alongside acceptance, is not ours yet.
                if (timeout_hit) begin
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                    state_d  = IDLE;
                end else if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (mem_rsp_valid) begin
                    rsp_fire = 1'b1;
                    rsp_data = mem_rsp_data;
                    state_d  = IDLE;
                end else if (timeout_hit) begin
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rsp_fire) begin
            if (last_owner_q == OWN_LS) begin
                ls_rsp_valid_d = 1'b1;
                ls_rsp_err_d   = rsp_err;
                ls_rsp_data_d  = rsp_data;
            end else begin
                if_rsp_valid_d = 1'b1;
                if_rsp_err_d   = rsp_err;
                if_rsp_data_d  = rsp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_owner_q   <= OWN_IF;
            cnt_q          <= 16'd0;
            addr_q         <= 32'h0;
            wen_q          <= 1'b0;
            wdata_q        <= 32'h0;
            wmask_q        <= 4'h0;
            if_rsp_valid_q <= 1'b0;
            if_rsp_err_q   <= 1'b0;
            if_rsp_data_q  <= 32'h0;
            ls_rsp_valid_q <= 1'b0;
            ls_rsp_err_q   <= 1'b0;
            ls_rsp_data_q  <= 32'h0;
        end else begin
            state_q        <= state_d;
            last_owner_q   <= last_owner_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            wen_q          <= wen_d;
            wdata_q        <= wdata_d;
            wmask_q        <= wmask_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            if_rsp_err_q   <= if_rsp_err_d;
            if_rsp_data_q  <= if_rsp_data_d;
            ls_rsp_valid_q <= ls_rsp_valid_d;
            ls_rsp_err_q   <= ls_rsp_err_d;
            ls_rsp_data_q  <= ls_rsp_data_d;
        end
    end

    assign if_req_ready  = grant_if;
    assign ls_req_ready  = grant_ls;

    assign mem_req_valid = (state_q == ISSUE);
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;

    assign if_rsp_valid  = if_rsp_valid_q;
    assign if_rsp_err    = if_rsp_err_q;
    assign if_rsp_data   = if_rsp_data_q;
    assign ls_rsp_valid  = ls_rsp_valid_q;
    assign ls_rsp_err    = ls_rsp_err_q;
    assign ls_rsp_data   = ls_rsp_data_q;

endmodule

// File: doc/ysyx_23060072_mem_arbiter.md
YSYX_23060072_MEM_ARBITER -- requirements
Module: ysyx_23060072_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, the max cycles in ISSUE+WAIT before a forced error completion (legal range 2..65535).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports if_req_valid in 1, if_req_addr in 32, if_req_ready out 1: instruction-fetch request channel.
REQ-005 SHALL have ports if_rsp_valid out 1, if_rsp_data out 32, if_rsp_err out 1: fetch response channel, with no backpressure.
REQ-006 SHALL have ports ls_req_valid in 1, ls_req_addr in 32, ls_req_wen in 1, ls_req_wdata in 32, ls_req_wmask in 4, ls_req_ready out 1: load/store request channel.
REQ-007 SHALL have ports ls_rsp_valid out 1, ls_rsp_data out 32, ls_rsp_err out 1: load/store response channel, with no backpressure.
REQ-008 SHALL have ports mem_req_valid out 1, mem_req_addr out 32, mem_req_wen out 1, mem_req_wdata out 32, mem_req_wmask out 4, mem_req_ready in 1: shared memory request port.
REQ-009 SHALL have ports mem_rsp_valid in 1, mem_rsp_data in 32: shared memory response port.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT; there is at most one outstanding memory transaction.
REQ-011 SHALL in IDLE grant a requester whose req_valid=1, asserting its req_ready combinationally in that same cycle, and go to ISSUE on the next edge.
REQ-012 SHALL on a tie grant the requester not served last, using a last_owner flag updated at each grant; a single valid requester is always granted.
REQ-013 SHALL never assert if_req_ready or ls_req_ready outside IDLE, nor both in the same cycle.
REQ-014 SHALL latch addr/wen/wdata/wmask at the grant edge; a fetch grant latches wen=0, wdata=0, wmask=0.
REQ-015 SHALL drive mem_req_* only from the latched registers.
REQ-016 SHALL in ISSUE hold mem_req_valid=1 with stable fields until mem_req_ready=1, then go to WAIT with mem_req_valid=0 from the next cycle.
REQ-017 SHALL ignore mem_rsp_valid in any state other than WAIT, including a response arriving in the same cycle as acceptance.
REQ-018 SHALL in WAIT, on mem_rsp_valid=1, register mem_rsp_data into the owner's rsp_data and pulse the owner's rsp_valid for exactly one cycle (the cycle after mem_rsp_valid), with rsp_err=0, and return to IDLE.
REQ-019 SHALL complete writes the same as reads; the write response data is mem_rsp_data and is don't-care to the LSU.
REQ-020 SHALL give minimum latency grant->rsp_valid of 3 cycles (grant T, ISSUE T+1 accepted, WAIT T+2 response, rsp_valid T+3).
REQ-021 SHALL allow a new grant in the same cycle as the rsp_valid pulse.
REQ-022 SHALL count cycles spent in ISSUE+WAIT with a 16-bit counter that is cleared on grant.
REQ-023 SHALL when the counter reaches TIMEOUT_CYC force the owner's rsp_valid=1, rsp_err=1, rsp_data=0 for one cycle, drop mem_req_valid, and return to IDLE.
REQ-024 SHALL hold rsp_data at its last value when rsp_valid=0, and hold rsp_err=0 except during an error pulse.
REQ-025 SHALL not assert the non-owner's rsp_valid in any cycle.

Reset
REQ-026 SHALL on rst_n=0 immediately reset: state=IDLE, last_owner=IF (so LSU wins the first tie), counter=0, all latched fields=0, all *_rsp_valid/err/data=0, mem_req_valid=0.
REQ-027 SHALL abandon any in-flight transaction on reset without a response, and ignore a stale mem_rsp_valid after reset release unless in WAIT.

Verification
REQ-028 SHALL verify single fetch: if_req_valid=1, addr=0x80000004; mem_req_ready=1 at T+1; mem_rsp_valid=1, data=0x00500093 at T+2 -> if_rsp_valid=1, data=0x00500093, err=0 at T+3 only.
REQ-029 SHALL verify tie sequence: both valid continuously from reset -> grant order LSU, IF, LSU, IF, with if_req_ready and ls_req_ready never high together.
REQ-030 SHALL verify a store: ls wen=1, addr=0x80000100, wdata=0xDEADBEEF, wmask=0xF; mem_req_ready held 0 for 5 cycles -> mem_req_* stable for all 6 cycles, ls_rsp_valid one cycle after mem_rsp_valid.
REQ-031 SHALL verify timeout with TIMEOUT_CYC=8: mem_req_ready held 0 -> rsp_valid=1, err=1, data=0 after 8 ISSUE cycles, then IDLE; a late mem_rsp_valid is ignored.
REQ-032 SHALL verify reset mid-operation: rst_n=0 in WAIT -> all outputs 0 asynchronously, no rsp pulse; mem_rsp_valid=1 after release in IDLE -> no response.
